// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Imported by fetch_controller and fetch_pc_reg.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    FLUSH
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch PC register with hold / +4 / aligned-redirect mux.
// Also tracks a sticky flag for misaligned redirect targets.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            advance,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] pc,
  output logic            misaligned_err
);

  logic [XLEN-1:0] pc_d, pc_q;
  logic            mis_d, mis_q;

  always_comb begin
    pc_d  = pc_q;
    mis_d = mis_q;
    if (redirect_valid) begin
      pc_d  = {redirect_target[XLEN-1:2], 2'b00};
      mis_d = mis_q | (|redirect_target[1:0]);
    end else if (advance) begin
      // Wraps modulo 2^32 by width truncation.
      pc_d = pc_q + XLEN'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
    end
  end

  assign pc             = pc_q;
  assign misaligned_err = mis_q;

endmodule

// File: rtl/fetch_controller.sv
// Stall- and redirect-aware fetch sequencer: one outstanding
// imem request, a one-entry holding register toward decode.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        misaligned_err
);

  fetch_state_t state_d, state_q;
  logic [31:0]  inflight_pc_d, inflight_pc_q;
  logic [31:0]  inst_data_d, inst_data_q;
  logic [31:0]  inst_pc_d, inst_pc_q;
  logic         inst_valid_d, inst_valid_q;
  logic         accept;
  logic         advance;
  logic [31:0]  pc;

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk            (clk),
    .reset          (reset),
    .advance        (advance),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .pc             (pc),
    .misaligned_err (misaligned_err)
  );

  assign accept = (state_q == REQ) && imem_req_ready;

  always_comb begin
    state_d       = state_q;
    inflight_pc_d = inflight_pc_q;
    inst_data_d   = inst_data_q;
    inst_pc_d     = inst_pc_q;
    inst_valid_d  = inst_valid_q;
    advance       = 1'b0;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (accept) begin
          inflight_pc_d = pc;
          advance       = 1'b1;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          inst_data_d  = imem_rsp_data;
          inst_pc_d    = inflight_pc_q;
          inst_valid_d = 1'b1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end
      end
      FLUSH: begin
        if (imem_rsp_valid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    // Redirect wins; an accepted or pending fetch becomes stale.
    if (redirect_valid) begin
      inst_data_d  = inst_data_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = 1'b0;
      unique case (state_q)
        IDLE:    state_d = REQ;
        REQ:     state_d = accept ? FLUSH : REQ;
        WAIT:    state_d = imem_rsp_valid ? REQ : FLUSH;
        HOLD:    state_d = REQ;
        FLUSH:   state_d = imem_rsp_valid ? REQ : FLUSH;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      inflight_pc_q <= '0;
      inst_data_q   <= '0;
      inst_pc_q     <= '0;
      inst_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      inflight_pc_q <= inflight_pc_d;
      inst_data_q   <= inst_data_d;
      inst_pc_q     <= inst_pc_d;
      inst_valid_q  <= inst_valid_d;
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = inst_valid_q;
  assign inst_data      = inst_data_q;
  assign inst_pc        = inst_pc_q;

endmodule
